// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 key schedule blocks.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_e;

  // Round constant word for rounds 1..10; anything else yields zero.
  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [31:0] word;
    case (r)
      4'd1:    word = 32'h01000000;
      4'd2:    word = 32'h02000000;
      4'd3:    word = 32'h04000000;
      4'd4:    word = 32'h08000000;
      4'd5:    word = 32'h10000000;
      4'd6:    word = 32'h20000000;
      4'd7:    word = 32'h40000000;
      4'd8:    word = 32'h80000000;
      4'd9:    word = 32'h1b000000;
      4'd10:   word = 32'h36000000;
      default: word = 32'h00000000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/aes_key_expand_128_inv_if.sv
// Load/advance/readout bundle between the key expander and the inverse cipher.
interface aes_key_expand_128_inv_if;
  logic         kld;
  logic [127:0] key;
  logic         next;
  logic         busy;
  logic         key_valid;
  logic [3:0]   rnd;
  logic [31:0]  wo_0;
  logic [31:0]  wo_1;
  logic [31:0]  wo_2;
  logic [31:0]  wo_3;

  modport master (
    output kld, key, next,
    input  busy, key_valid, rnd, wo_0, wo_1, wo_2, wo_3
  );

  modport slave (
    input  kld, key, next,
    output busy, key_valid, rnd, wo_0, wo_1, wo_2, wo_3
  );
endinterface

// File: rtl/aes_key_round.sv
// One key-schedule round in either direction, sharing a single set of S-boxes.
module aes_key_round (
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [31:0] w2_i,
  input  logic [31:0] w3_i,
  input  logic [31:0] rcon_i,
  input  logic        dir_i,
  output logic [31:0] w0_o,
  output logic [31:0] w1_o,
  output logic [31:0] w2_o,
  output logic [31:0] w3_o
);

  logic [31:0] inv_w3;
  logic [31:0] sbox_in;
  logic [31:0] rot_in;
  logic [31:0] sub_out;

  assign inv_w3  = w3_i ^ w2_i;
  assign sbox_in = dir_i ? inv_w3 : w3_i;
  assign rot_in  = {sbox_in[23:0], sbox_in[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot_in[i*8 +: 8]),
      .y (sub_out[i*8 +: 8])
    );
  end

  // Forward rebuilds words left-to-right; inverse peels them right-to-left.
  always_comb begin
    w0_o = w0_i;
    w1_o = w1_i;
    w2_o = w2_i;
    w3_o = w3_i;
    if (dir_i) begin
      w3_o = inv_w3;
      w2_o = w2_i ^ w1_i;
      w1_o = w1_i ^ w0_i;
      w0_o = w0_i ^ sub_out ^ rcon_i;
    end else begin
      w0_o = w0_i ^ sub_out ^ rcon_i;
      w1_o = w1_i ^ w0_o;
      w2_o = w2_i ^ w1_o;
      w3_o = w3_i ^ w2_o;
    end
  end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte, purely combinational table lookup.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte substitution is a direct index into the constant table.
  always_comb begin
    y = SBOX[a];
  end

endmodule

// File: rtl/aes_key_expand_128_inv.sv
// Expands a loaded key to round 10, then walks the schedule back to round 0.
module aes_key_expand_128_inv
  import aes_pkg::*;
(
  input logic                       clk,
  input logic                       rst_n,
  aes_key_expand_128_inv_if.slave   bus
);

  state_e      state_q, state_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        busy_q, busy_d;
  logic        key_valid_q, key_valid_d;
  logic [31:0] w0_q, w1_q, w2_q, w3_q;
  logic [31:0] w0_d, w1_d, w2_d, w3_d;
  logic [31:0] r0, r1, r2, r3;
  logic        dir;
  logic [3:0]  rcon_sel;

  assign dir      = (state_q == READY);
  assign rcon_sel = dir ? rnd_q : rnd_q + 4'd1;

  aes_key_round u_round (
    .w0_i   (w0_q),
    .w1_i   (w1_q),
    .w2_i   (w2_q),
    .w3_i   (w3_q),
    .rcon_i (rcon(rcon_sel)),
    .dir_i  (dir),
    .w0_o   (r0),
    .w1_o   (r1),
    .w2_o   (r2),
    .w3_o   (r3)
  );

  // Next-state: load wins, then forward expansion, then guarded inverse steps.
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    busy_d      = busy_q;
    key_valid_d = key_valid_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    w3_d        = w3_q;
    if (bus.kld) begin
      w0_d        = bus.key[127:96];
      w1_d        = bus.key[95:64];
      w2_d        = bus.key[63:32];
      w3_d        = bus.key[31:0];
      rnd_d       = 4'd0;
      state_d     = EXPAND;
      busy_d      = 1'b1;
      key_valid_d = 1'b0;
    end else begin
      case (state_q)
        EXPAND: begin
          {w0_d, w1_d, w2_d, w3_d} = {r0, r1, r2, r3};
          rnd_d = rnd_q + 4'd1;
          if (rnd_q == 4'(NR - 1)) begin
            state_d     = READY;
            busy_d      = 1'b0;
            key_valid_d = 1'b1;
          end
        end
        READY: begin
          if (bus.next && (rnd_q != 4'd0)) begin
            {w0_d, w1_d, w2_d, w3_d} = {r0, r1, r2, r3};
            rnd_d = rnd_q - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State, counter and key words, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rnd_q       <= 4'd0;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
      w0_q        <= 32'h0;
      w1_q        <= 32'h0;
      w2_q        <= 32'h0;
      w3_q        <= 32'h0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      busy_q      <= busy_d;
      key_valid_q <= key_valid_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      w3_q        <= w3_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.key_valid = key_valid_q;
  assign bus.rnd       = rnd_q;
  assign bus.wo_0      = w0_q;
  assign bus.wo_1      = w1_q;
  assign bus.wo_2      = w2_q;
  assign bus.wo_3      = w3_q;

endmodule

// File: tb/tb_aes_key_expand_128_inv.sv
// Bench for the inverse-order AES-128 key expander.
module tb_aes_key_expand_128_inv;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [7:0] sbox_tbl [256];

  aes_key_expand_128_inv_if bus ();

  aes_key_expand_128_inv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  function automatic logic [7:0] sboxMath(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) sbox_tbl[i] = sboxMath(8'(i));
  end

  function automatic logic [31:0] subWord(input logic [31:0] v);
    return {sbox_tbl[v[31:24]], sbox_tbl[v[23:16]], sbox_tbl[v[15:8]], sbox_tbl[v[7:0]]};
  endfunction

  // Textbook FIPS-197 key expansion; returns round key r as a 128-bit value.
  function automatic logic [127:0] roundKey(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = k[127:96];
    w[1] = k[95:64];
    w[2] = k[63:32];
    w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic checkOutput(input string name, input logic [133:0] act, input logic [133:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic kld, input logic [127:0] key, input logic next);
    @(posedge clk);
    #1;
    bus.kld  = kld;
    bus.key  = key;
    bus.next = next;
  endtask

  // Behavioural view: which key is loaded, how far along, and whether readout is live.
  logic         m_loaded;
  logic         m_expanding;
  logic         m_valid;
  int           m_rnd;
  logic [127:0] m_key;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loaded    <= 1'b0;
      m_expanding <= 1'b0;
      m_valid     <= 1'b0;
      m_rnd       <= 0;
      m_key       <= '0;
    end else if (bus.kld) begin
      m_loaded    <= 1'b1;
      m_expanding <= 1'b1;
      m_valid     <= 1'b0;
      m_rnd       <= 0;
      m_key       <= bus.key;
    end else if (m_expanding) begin
      m_rnd <= m_rnd + 1;
      if (m_rnd + 1 == 10) begin
        m_expanding <= 1'b0;
        m_valid     <= 1'b1;
      end
    end else if (m_valid && bus.next && m_rnd > 0) begin
      m_rnd <= m_rnd - 1;
    end
  end

  // Every falling edge the DUT must agree with the model on all outputs.
  always @(negedge clk) begin
    logic [127:0] exp_wo;
    exp_wo = m_loaded ? roundKey(m_key, m_rnd) : 128'h0;
    checkOutput("cycle",
                {bus.busy, bus.key_valid, bus.rnd, bus.wo_0, bus.wo_1, bus.wo_2, bus.wo_3},
                {m_expanding, m_valid, 4'(m_rnd), exp_wo});
  end

  function automatic logic [133:0] outs();
    return {bus.busy, bus.key_valid, bus.rnd, bus.wo_0, bus.wo_1, bus.wo_2, bus.wo_3};
  endfunction

  initial begin
    logic [127:0] rkey;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    bus.kld  = 1'b0;
    bus.key  = '0;
    bus.next = 1'b0;

    #12;
    checkOutput("reset_state", outs(), 134'h0);
    checkOutput("model_sbox_00", {126'h0, sbox_tbl[8'h00]}, 134'h63);
    checkOutput("model_sbox_53", {126'h0, sbox_tbl[8'h53]}, 134'hed);
    checkOutput("model_fips_r1", {6'h0, roundKey(FIPS_KEY, 1)}, {6'h0, 128'ha0fafe1788542cb123a339392a6c7605});
    checkOutput("model_zero_r10", {6'h0, roundKey(128'h0, 10)}, {6'h0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e});
    #1 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("idle_next_ignored", outs(), 134'h0);

    // FIPS key, one-cycle load, next poked during expansion.
    applyStimulus(1'b1, FIPS_KEY, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, (i % 3 == 1));
    checkOutput("pre_valid_edge", {128'h0, outs()[133:128]}, {128'h0, 1'b1, 1'b0, 4'd9});
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("fips_r10", outs(), {1'b0, 1'b1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("fips_r9", outs(), {1'b0, 1'b1, 4'd9, 128'hac7766f319fadc2128d12941575c006e});
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("fips_r1", outs(), {1'b0, 1'b1, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605});
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("fips_r0", outs(), {1'b0, 1'b1, 4'd0, FIPS_KEY});
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("r0_hold", outs(), {1'b0, 1'b1, 4'd0, FIPS_KEY});
    applyStimulus(1'b0, '0, 1'b0);

    // Reload with the zero key from READY at round 5, with next also high.
    applyStimulus(1'b1, FIPS_KEY, 1'b0);
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 128'h0, 1'b1);
    checkOutput("before_reload_r5", {128'h0, outs()[133:128]}, {128'h0, 1'b0, 1'b1, 4'd5});
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("reload_wins", outs(), {1'b1, 1'b0, 4'd0, 128'h0});
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("zero_r10", outs(), {1'b0, 1'b1, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e});

    // Asynchronous reset in the middle of an expansion.
    applyStimulus(1'b1, FIPS_KEY, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", outs(), 134'h0);
    #4 rst_n = 1'b1;
    applyStimulus(1'b1, FIPS_KEY, 1'b0);
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("after_reset_r10", outs(), {1'b0, 1'b1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

    // Random keys: full forward expansion then full inverse walk.
    for (int n = 0; n < 1000; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, rkey, 1'b0);
      for (int i = 0; i < 11; i++) applyStimulus(1'b0, '0, 1'b0);
      for (int i = 0; i < 11; i++) applyStimulus(1'b0, '0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("random_r0", outs(), {1'b0, 1'b1, 4'd0, rkey});
    end

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
